serial_pair_serializer_using_fsm: RTL and testbench

- Parallel-to-serial transmitter for the bit-serial comparator path.
- Accepts a pair of W-bit operands (A, B) through a valid/ready handshake and shifts them out as two synchronous one-bit streams a, b, one bit per clock.
- Bit order is LSB-first or MSB-first, selected by parameter.
- Emits first/last framing so a downstream serial comparator can be cleared at word start and sampled at word end.

---
 rtl/serial_pkg.sv | 14 +
 rtl/serial_shift_out.sv | 47 ++++
 rtl/serial_pair_serializer_using_fsm.sv | 104 ++++++++++
 tb/tb_serial_pair_serializer_using_fsm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state type and sizing helper for the serial pair transmitter
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must hold W-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_shift_out.sv
// rtl/serial_shift_out.sv - load/shift register with a registered serial bit output
module serial_shift_out #(
  parameter int W         = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         clear,
  input  logic [W-1:0] data,
  output logic         bit_out
);

  logic [W-1:0] sreg;
  logic         bit_q;

  assign bit_out = bit_q;

  // The bit on the wire is held in bit_q; sreg keeps the bits still to be sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg  <= '0;
      bit_q <= 1'b0;
    end else if (load) begin
      if (MSB_FIRST) begin
        bit_q <= data[W-1];
        sreg  <= {data[W-2:0], 1'b0};
      end else begin
        bit_q <= data[0];
        sreg  <= {1'b0, data[W-1:1]};
      end
    end else if (shift) begin
      if (MSB_FIRST) begin
        bit_q <= sreg[W-1];
        sreg  <= {sreg[W-2:0], 1'b0};
      end else begin
        bit_q <= sreg[0];
        sreg  <= {1'b0, sreg[W-1:1]};
      end
    end else if (clear) begin
      sreg  <= '0;
      bit_q <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_pair_serializer_using_fsm.sv
// rtl/serial_pair_serializer_using_fsm.sv - valid/ready operand pair to framed two-bit serial stream
module serial_pair_serializer_using_fsm
  import serial_pkg::*;
#(
  parameter int W         = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_a,
  input  logic [W-1:0] up_b,
  output logic         a,
  output logic         b,
  output logic         down_valid,
  output logic         first,
  output logic         last
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          hs, load, shift, clear;
  logic          first_d, last_d, valid_d;

  assign up_ready = (state == IDLE) || (cnt == CNT_LAST);
  assign hs       = up_valid & up_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      down_valid <= 1'b0;
      first      <= 1'b0;
      last       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      down_valid <= valid_d;
      first      <= first_d;
      last       <= last_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    shift   = 1'b0;
    clear   = 1'b0;
    case (state)
      IDLE: begin
        if (hs) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          // A handshake on the final bit reloads with no bubble between words.
          if (hs) begin
            load = 1'b1;
          end else begin
            clear   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          shift = 1'b1;
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == SHIFT);
    first_d = load;
    last_d  = (state_d == SHIFT) && (cnt_d == CNT_LAST);
  end

  serial_shift_out #(.W(W), .MSB_FIRST(MSB_FIRST)) u_shift_a (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .clear   (clear),
    .data    (up_a),
    .bit_out (a)
  );

  serial_shift_out #(.W(W), .MSB_FIRST(MSB_FIRST)) u_shift_b (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .clear   (clear),
    .data    (up_b),
    .bit_out (b)
  );

endmodule

// File: tb/tb_serial_pair_serializer_using_fsm.sv
// tb/tb_serial_pair_serializer_using_fsm.sv - directed bench for the serial pair serializer
module tb_serial_pair_serializer_using_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] up_a, up_b;
  logic        vl, vm;
  logic        rdy_l, a_l, b_l, dv_l, f_l, l_l;
  logic        rdy_m, a_m, b_m, dv_m, f_m, l_m;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  serial_pair_serializer_using_fsm #(.W(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .up_valid(vl), .up_ready(rdy_l), .up_a(up_a), .up_b(up_b),
    .a(a_l), .b(b_l), .down_valid(dv_l), .first(f_l), .last(l_l)
  );

  serial_pair_serializer_using_fsm #(.W(16), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .up_valid(vm), .up_ready(rdy_m), .up_a(up_a), .up_b(up_b),
    .a(a_m), .b(b_m), .down_valid(dv_m), .first(f_m), .last(l_m)
  );

  task automatic test_reset();
    rst = 1'b1; vl = 1'b0; vm = 1'b0; up_a = '0; up_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_l, b_l, dv_l, f_l, l_l, a_m, b_m, dv_m, f_m, l_m} !== 10'b0) begin
      failures++; $display("FAIL reset_outputs: got %b expected 0", {a_l, b_l, dv_l, f_l, l_l, a_m, b_m, dv_m, f_m, l_m});
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rdy_l, rdy_m} !== 2'b11) begin
        failures++; $display("FAIL idle_ready cycle %0d: got %b expected 11", i, {rdy_l, rdy_m});
      end
      checks++;
      if ({a_l, b_l, dv_l, f_l, l_l, a_m, b_m, dv_m, f_m, l_m} !== 10'b0) begin
        failures++; $display("FAIL idle_outputs cycle %0d: got %b expected 0", i, {a_l, b_l, dv_l, f_l, l_l});
      end
    end
  endtask

  task automatic test_lsb_single();
    logic [15:0] ea, eb;
    logic        lt, gt;
    ea = 16'b0100_0001_0010_0110;
    eb = 16'b0100_0110_0100_0110;
    lt = 1'b0; gt = 1'b0;
    up_a = ea; up_b = eb; vl = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      vl = 1'b0;
      if (f_l) begin lt = 1'b0; gt = 1'b0; end
      if (a_l != b_l) begin lt = b_l; gt = a_l; end
      checks++;
      if ({a_l, b_l} !== {ea[j], eb[j]}) begin
        failures++; $display("FAIL lsb_bits j=%0d: got %b expected %b", j, {a_l, b_l}, {ea[j], eb[j]});
      end
      checks++;
      if ({dv_l, f_l, l_l, rdy_l} !== {1'b1, j == 0, j == 15, j == 15}) begin
        failures++; $display("FAIL lsb_frame j=%0d: got %b expected %b", j, {dv_l, f_l, l_l, rdy_l}, {1'b1, j == 0, j == 15, j == 15});
      end
    end
    checks++;
    if ({lt, gt} !== 2'b10) begin
      failures++; $display("FAIL lsb_compare: got lt/gt %b expected 10", {lt, gt});
    end
    @(negedge clk);
    checks++;
    if ({a_l, b_l, dv_l, f_l, l_l, rdy_l} !== 6'b000001) begin
      failures++; $display("FAIL lsb_return_idle: got %b expected 000001", {a_l, b_l, dv_l, f_l, l_l, rdy_l});
    end
  endtask

  task automatic test_msb_single();
    logic [15:0] ea, eb;
    logic        lt, gt;
    int          decided;
    ea = 16'h4126; eb = 16'h4646;
    lt = 1'b0; gt = 1'b0; decided = -1;
    up_a = ea; up_b = eb; vm = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      vm = 1'b0;
      if (f_m) begin lt = 1'b0; gt = 1'b0; end
      if (!lt && !gt && a_m != b_m) begin lt = b_m; gt = a_m; decided = j; end
      checks++;
      if ({a_m, b_m} !== {ea[15-j], eb[15-j]}) begin
        failures++; $display("FAIL msb_bits j=%0d: got %b expected %b", j, {a_m, b_m}, {ea[15-j], eb[15-j]});
      end
      checks++;
      if ({dv_m, f_m, l_m, rdy_m} !== {1'b1, j == 0, j == 15, j == 15}) begin
        failures++; $display("FAIL msb_frame j=%0d: got %b expected %b", j, {dv_m, f_m, l_m, rdy_m}, {1'b1, j == 0, j == 15, j == 15});
      end
    end
    // First differing bit is index 10 (6th on the wire), where B holds the 1.
    checks++;
    if ({lt, gt, decided} !== {2'b10, 32'd5}) begin
      failures++; $display("FAIL msb_compare: got lt/gt %b at step %0d expected 10 at step 5", {lt, gt}, decided);
    end
    @(negedge clk);
    checks++;
    if ({a_m, b_m, dv_m, f_m, l_m, rdy_m} !== 6'b000001) begin
      failures++; $display("FAIL msb_return_idle: got %b expected 000001", {a_m, b_m, dv_m, f_m, l_m, rdy_m});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa [3];
    logic [15:0] pb [3];
    logic [15:0] wa, wb;
    int          k, w;
    pa[0] = 16'h4126; pb[0] = 16'h4646;
    pa[1] = 16'h4106; pb[1] = 16'h5646;
    pa[2] = 16'h4726; pb[2] = 16'h4726;
    up_a = pa[0]; up_b = pb[0]; vl = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      w = c / 16; k = c % 16;
      wa = pa[w]; wb = pb[w];
      checks++;
      if ({dv_l, a_l, b_l} !== {1'b1, wa[k], wb[k]}) begin
        failures++; $display("FAIL b2b_data c=%0d: got %b expected %b", c, {dv_l, a_l, b_l}, {1'b1, wa[k], wb[k]});
      end
      checks++;
      if ({f_l, l_l, rdy_l} !== {k == 0, k == 15, k == 15}) begin
        failures++; $display("FAIL b2b_frame c=%0d: got %b expected %b", c, {f_l, l_l, rdy_l}, {k == 0, k == 15, k == 15});
      end
      if (k == 15) begin
        if (w < 2) begin up_a = pa[w+1]; up_b = pb[w+1]; end
        else vl = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if ({dv_l, f_l, l_l, a_l, b_l} !== 5'b0) begin
      failures++; $display("FAIL b2b_end: got %b expected 00000", {dv_l, f_l, l_l, a_l, b_l});
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] ea, eb;
    up_a = 16'hFFFF; up_b = 16'hFFFF; vl = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      vl = 1'b0;
    end
    checks++;
    if ({dv_l, a_l, b_l} !== 3'b111) begin
      failures++; $display("FAIL mid_pre_reset: got %b expected 111", {dv_l, a_l, b_l});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_l, b_l, dv_l, f_l, l_l} !== 5'b0) begin
      failures++; $display("FAIL mid_async_reset: got %b expected 00000", {a_l, b_l, dv_l, f_l, l_l});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({rdy_l, dv_l} !== 2'b10) begin
      failures++; $display("FAIL mid_after_reset: got ready/valid %b expected 10", {rdy_l, dv_l});
    end
    ea = 16'h0001; eb = 16'h8000;
    up_a = ea; up_b = eb; vl = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      vl = 1'b0;
      checks++;
      if ({dv_l, f_l, l_l, a_l, b_l} !== {1'b1, j == 0, j == 15, ea[j], eb[j]}) begin
        failures++; $display("FAIL mid_new_word j=%0d: got %b expected %b", j, {dv_l, f_l, l_l, a_l, b_l}, {1'b1, j == 0, j == 15, ea[j], eb[j]});
      end
    end
    @(negedge clk);
    checks++;
    if ({dv_l, a_l, b_l} !== 3'b0) begin
      failures++; $display("FAIL mid_word_end: got %b expected 000", {dv_l, a_l, b_l});
    end
  endtask

  task automatic test_input_stability();
    logic [15:0] ea, eb;
    ea = 16'hA5C3; eb = 16'h3C5A;
    up_a = ea; up_b = eb; vl = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      vl = 1'b0;
      up_a = 16'($urandom); up_b = 16'($urandom);
      checks++;
      if ({a_l, b_l} !== {ea[j], eb[j]}) begin
        failures++; $display("FAIL stable_bits j=%0d: got %b expected %b", j, {a_l, b_l}, {ea[j], eb[j]});
      end
    end
    @(negedge clk);
    checks++;
    if ({dv_l, rdy_l} !== 2'b01) begin
      failures++; $display("FAIL stable_end: got valid/ready %b expected 01", {dv_l, rdy_l});
    end
  endtask

  initial begin
    test_reset();
    test_lsb_single();
    test_msb_single();
    test_back_to_back();
    test_mid_reset();
    test_input_stability();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
